// File: rtl/ham_seq_unit_if.sv
// Handshake bundle between the execute stage and the Hamming-weight unit.
// Handshake: the master raises start with op_a valid and keeps it high until
// it sees busy=0 at the accepting edge; the unit samples op_a only on the
// edge where it accepts (idle, start=1, flush=0). Completion is signalled by
// done, a single-cycle pulse with result valid in that same cycle. flush is a
// synchronous abort that beats start and suppresses any pending done.
interface ham_seq_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic [DATA_W-1:0] op_a;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start,
    output flush,
    output op_a,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  flush,
    input  op_a,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/ham_seq_unit.sv
// Multi-cycle popcount unit: counts SLICE_W operand bits per cycle and
// returns a zero-extended count.
// Optional feature macro: HAM_EARLY_EXIT_EN -- finish as soon as the
// remaining shifted operand is all zero instead of always running NSLICE
// count cycles.
module ham_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ham_seq_unit_if.slave       bus,
  output logic [1:0]          dbg_state_o
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int ACC_W  = $clog2(DATA_W + 1);
  localparam int CNT_W  = $clog2(NSLICE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    slice_pop;
  logic [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]   shreg_nxt;
  logic                last_slice;

  function automatic logic [ACC_W-1:0] slice_popcount(input logic [SLICE_W-1:0] s);
    logic [ACC_W-1:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      c = c + {{(ACC_W-1){1'b0}}, s[i]};
    end
    return c;
  endfunction

  // Datapath for one count step: popcount of the low slice and the shifted operand.
  always_comb begin
    slice_pop = slice_popcount(shreg_q[SLICE_W-1:0]);
    acc_sum   = acc_q + slice_pop;
    shreg_nxt = shreg_q >> SLICE_W;
`ifdef HAM_EARLY_EXIT_EN
    last_slice = (cnt_q == CNT_W'(1)) || (shreg_nxt == '0);
`else
    last_slice = (cnt_q == CNT_W'(1));
`endif
  end

  // Next-state and register-next logic; flush overrides everything except result.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          shreg_d = bus.op_a;
          acc_d   = '0;
          cnt_d   = CNT_W'(NSLICE);
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        acc_d   = acc_sum;
        shreg_d = shreg_nxt;
        cnt_d   = cnt_q - CNT_W'(1);
        if (last_slice) begin
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = {{(DATA_W-ACC_W){1'b0}}, result_q};
  assign dbg_state_o = state_q;

endmodule
